// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one result bit per clock, LSB first.
//
// A start seen in IDLE captures a, b and cin. The block then spends WIDTH
// cycles in SHIFT, producing one sum bit per edge. It then spends exactly one
// cycle in DONE, where done is high, and returns to IDLE. sum and cout keep
// their values until the next accepted start.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output. ovf is
// the signed overflow of the addition: the carry into the MSB XOR the final
// carry-out. It is registered together with cout.
//
// Handshake: start is a request that is sampled only while busy is low
// (IDLE). A start raised while busy is high is dropped, not queued. done is a
// single-cycle strobe that qualifies sum/cout (and ovf).
//
// dbg_state exposes the FSM encoding (00 IDLE, 01 SHIFT, 10 DONE) for
// checkers.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Counter needs to reach WIDTH-1 without wrapping; one spare bit keeps
    // the terminal value representable for every legal WIDTH.
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             c_next;
    logic             last;
    logic             accept;

    // Full adder on the current operand LSBs and the running carry.
    assign bit_s  = sa[0] ^ sb[0] ^ carry;
    assign c_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && start;

    assign busy      = (state == SHIFT) || (state == DONE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // State register: IDLE -> SHIFT on start, WIDTH SHIFT cycles, one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= SHIFT;
                SHIFT:   if (last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and carry capture on accept, then one serial step per SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= c_next;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers: sum fills from the MSB end so bit 0 lands at the LSB
    // after WIDTH steps; cout is loaded only by the final step and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == SHIFT) begin
            sum <= {bit_s, sum[WIDTH-1:1]};
            if (last) cout <= c_next;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: on the last step, carry holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if ((state == SHIFT) && last) begin
            ovf <= carry ^ c_next;
        end
    end
`endif

endmodule
